math_req: RTL

- Clocked initiator for the self-timed arithmetic units, which use a req/fin protocol: a posedge on req starts a computation, and fin then emits a short self-clearing pulse while so/couto hold the result.
- This block accepts operand pairs on a clocked valid/ready port and launches each pair as one req.
- It captures the asynchronous fin pulse safely, samples the result, and returns it on a clocked valid/ready port.
- It also raises an error if fin never arrives.

---
 rtl/math_req.sv | 139 +++++++++++++
 1 files changed

// File: rtl/math_req.sv
// Clocked req/fin initiator for a self-timed arithmetic unit: launches one operand
// pair per req, captures the async fin pulse via a toggle synchroniser, and times out.
// Optional macro MATH_REQ_LATENCY_EN adds a lat output with the REQ cycle count.
module math_req #(
    parameter int Width       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_x,
    input  logic [Width-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_s,
    output logic             out_cout,
    output logic             out_err,
`ifdef MATH_REQ_LATENCY_EN
    output logic [$clog2(TIMEOUT+1)-1:0] lat,
`endif
    output logic             req,
    output logic [Width-1:0] x,
    output logic [Width-1:0] y,
    input  logic             fin,
    input  logic [Width-1:0] so,
    input  logic             couto
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, REQ, DONE} state_t;

    state_t                 r_state, w_next;
    logic                   r_fin_tog;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_fin_ref;
    logic [CW-1:0]          r_cnt;
    logic                   r_req;
    logic [Width-1:0]       r_x, r_y, r_s;
    logic                   r_cout, r_err;
    logic                   w_fin_sync, w_complete, w_timeout, w_accept, w_release;

    // fin may be narrower than a clk period, so it is turned into a level change first
    always_ff @(posedge fin or posedge rst) begin
        if (rst) r_fin_tog <= 1'b0;
        else     r_fin_tog <= ~r_fin_tog;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], r_fin_tog};
    end

    assign w_fin_sync = r_sync[SYNC_STAGES-1];

    // Tracking the toggle outside REQ swallows stray or late fin pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_fin_ref <= 1'b0;
        else if (r_state != REQ) r_fin_ref <= w_fin_sync;
    end

    assign w_complete = (r_state == REQ) && (w_fin_sync != r_fin_ref);
    assign w_timeout  = (r_state == REQ) && (r_cnt == CW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_release = 1'b0;
        case (r_state)
            IDLE:  if (in_valid) begin
                       w_accept = 1'b1;
                       w_next   = SETUP;
                   end
            SETUP: w_next = REQ;
            REQ:   if (w_complete || w_timeout) w_next = DONE;
            DONE:  if (out_ready) begin
                       w_release = 1'b1;
                       w_next    = IDLE;
                   end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_cnt  <= '0;
            r_s    <= '0;
            r_cout <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            // req trails the REQ state by one edge so operands get a full setup cycle
            r_req <= (r_state == REQ) && (w_next == REQ);
            if (w_accept) begin
                r_x <= in_x;
                r_y <= in_y;
            end
            if (w_release)
                r_cnt <= '0;
            else if (r_state == REQ && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
            if (w_complete) begin
                r_s    <= so;
                r_cout <= couto;
                r_err  <= 1'b0;
            end else if (w_timeout) begin
                r_s    <= '0;
                r_cout <= 1'b0;
                r_err  <= 1'b1;
            end
        end
    end

`ifdef MATH_REQ_LATENCY_EN
    logic [CW-1:0] r_lat;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      r_lat <= '0;
        else if (r_state == REQ && w_next == DONE)    r_lat <= r_cnt;
    end
    assign lat = r_lat;
`endif

    assign req       = r_req;
    assign x         = r_x;
    assign y         = r_y;
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign out_s     = r_s;
    assign out_cout  = r_cout;
    assign out_err   = r_err;
endmodule
